// File: rtl/instr_prefetch_buffer.sv
// Instruction fetch front end: request/response fetch engine with an in-order prefetch FIFO.
// Optional PREFETCH_STATS_EN adds saturating drop / empty-cycle counters.
module instr_prefetch_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [63:0] instr_addr
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0] stat_dropped,
  output logic [31:0] stat_empty
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  // Handshake: a request transfers in any cycle where mem_req_valid && mem_req_ready;
  // responses need no ready and return strictly in request order.

  logic [63:0] fetch_pc_q, fetch_pc_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        pend_rd_ptr_q, pend_rd_ptr_d;
  ptr_t        pend_wr_ptr_q, pend_wr_ptr_d;
  cnt_t        count_q, count_d;
  cnt_t        outstanding_q, outstanding_d;
  cnt_t        drop_cnt_q, drop_cnt_d;

  logic [63:0] fifo_pc_q    [DEPTH];
  logic [31:0] fifo_instr_q [DEPTH];
  logic [63:0] pend_pc_q    [DEPTH];

  logic fire;
  logic rsp_drop;
  logic push;
  logic pop;

  // Credit check keeps FIFO entries plus in-flight requests within DEPTH, so a
  // response always has a free slot.
  always_comb begin
    mem_req_valid = !reset && !redirect &&
                    (({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_C);
    mem_req_addr  = fetch_pc_q;
    fire          = mem_req_valid && mem_req_ready;
    rsp_drop      = mem_rsp_valid && (drop_cnt_q != '0);
    push          = mem_rsp_valid && !rsp_drop && !redirect;
    pop           = instr_valid && !stall && !redirect;
  end

  always_comb begin
    instr_valid = (count_q != '0);
    instruction = instr_valid ? fifo_instr_q[rd_ptr_q] : NOP_INSTR;
    instr_addr  = instr_valid ? fifo_pc_q[rd_ptr_q] : 64'h0;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    pend_rd_ptr_d = pend_rd_ptr_q;
    pend_wr_ptr_d = pend_wr_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;

    if (fire) begin
      fetch_pc_d    = fetch_pc_q + 64'd4;
      pend_wr_ptr_d = pend_wr_ptr_q + 1'b1;
    end
    if (mem_rsp_valid) begin
      pend_rd_ptr_d = pend_rd_ptr_q + 1'b1;
    end

    case ({fire, mem_rsp_valid})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    if (rsp_drop) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Every request still in flight after this cycle belongs to the old path.
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      drop_cnt_d = outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      pend_rd_ptr_q <= '0;
      pend_wr_ptr_q <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      pend_rd_ptr_q <= pend_rd_ptr_d;
      pend_wr_ptr_q <= pend_wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      pend_pc_q[pend_wr_ptr_q] <= fetch_pc_q;
    end
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= pend_pc_q[pend_rd_ptr_q];
      fifo_instr_q[wr_ptr_q] <= mem_rsp_data;
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [31:0] stat_dropped_q, stat_dropped_d;
  logic [31:0] stat_empty_q, stat_empty_d;

  always_comb begin
    stat_dropped_d = stat_dropped_q;
    stat_empty_d   = stat_empty_q;
    if (mem_rsp_valid && (rsp_drop || redirect) && (stat_dropped_q != '1)) begin
      stat_dropped_d = stat_dropped_q + 32'd1;
    end
    if (!instr_valid && (stat_empty_q != '1)) begin
      stat_empty_d = stat_empty_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_dropped_q <= '0;
      stat_empty_q   <= '0;
    end else begin
      stat_dropped_q <= stat_dropped_d;
      stat_empty_q   <= stat_empty_d;
    end
  end

  assign stat_dropped = stat_dropped_q;
  assign stat_empty   = stat_empty_q;
`endif

`ifndef SYNTHESIS
  a_rsp_without_req: assert property (@(posedge clk) disable iff (reset)
    !(mem_rsp_valid && (outstanding_q == '0)));
  a_count_overflow: assert property (@(posedge clk) disable iff (reset)
    count_q <= cnt_t'(DEPTH));
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer: in-order memory model with fixed latency,
// hand-computed expectations per scenario. dut8 (DEPTH=8) covers the deep reset case.
module tb_instr_prefetch_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        sel8;

  logic        req_valid4, req_valid8;
  logic [63:0] req_addr4, req_addr8;
  logic        instr_valid4, instr_valid8;
  logic [31:0] instruction4, instruction8;
  logic [63:0] instr_addr4, instr_addr8;
  logic        ready4, ready8, rsp_valid4, rsp_valid8;

  assign ready4     = mem_req_ready && !sel8;
  assign ready8     = mem_req_ready && sel8;
  assign rsp_valid4 = mem_rsp_valid && !sel8;
  assign rsp_valid8 = mem_rsp_valid && sel8;

`ifdef PREFETCH_STATS_EN
  logic [31:0] stat_dropped4, stat_empty4, stat_dropped8, stat_empty8;
`endif

  instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(64'h0), .NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(req_valid4), .mem_req_addr(req_addr4), .mem_req_ready(ready4),
    .mem_rsp_valid(rsp_valid4), .mem_rsp_data(mem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .instr_valid(instr_valid4), .instruction(instruction4), .instr_addr(instr_addr4)
`ifdef PREFETCH_STATS_EN
    , .stat_dropped(stat_dropped4), .stat_empty(stat_empty4)
`endif
  );

  instr_prefetch_buffer #(.DEPTH(8), .RESET_PC(64'h1000), .NOP_INSTR(32'h00000013)) dut8 (
    .clk(clk), .reset(reset),
    .mem_req_valid(req_valid8), .mem_req_addr(req_addr8), .mem_req_ready(ready8),
    .mem_rsp_valid(rsp_valid8), .mem_rsp_data(mem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .instr_valid(instr_valid8), .instruction(instruction8), .instr_addr(instr_addr8)
`ifdef PREFETCH_STATS_EN
    , .stat_dropped(stat_dropped8), .stat_empty(stat_empty8)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int lat   = 1;
  int fires = 0;
  bit const_data = 1'b1;
  bit found;

  logic [63:0] mq_addr[$];
  int          mq_due[$];
  logic [63:0] exp_q[$];
  logic [63:0] exp_a;

  task check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return const_data ? 32'h00100093 : ({a[29:0], 2'b11} ^ 32'hA0000000);
  endfunction

  // One clock cycle: present any due response, record a request transfer, advance.
  task step();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    if (mq_due.size() != 0 && mq_due[0] <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(mq_addr[0]);
      void'(mq_due.pop_front());
      void'(mq_addr.pop_front());
    end
    #1;
    if (sel8 ? (req_valid8 && ready8) : (req_valid4 && ready4)) begin
      mq_addr.push_back(sel8 ? req_addr8 : req_addr4);
      mq_due.push_back(cyc + lat);
      fires++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task do_reset();
    reset         = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = 64'h0;
    stall         = 1'b0;
    mem_req_ready = 1'b1;
    mq_addr.delete();
    mq_due.delete();
    step();
    step();
    reset = 1'b0;
    cyc   = 0;
    fires = 0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    redirect = 1'b0; redirect_pc = 64'h0; stall = 1'b0; sel8 = 1'b0;
    @(negedge clk);

    // Streaming with 1-cycle memory
    const_data = 1'b1; lat = 1;
    do_reset();
    check("t1_reset_valid", 64'(instr_valid4), 64'd0);
    check("t1_reset_instr", 64'(instruction4), 64'h13);
    check("t1_reset_addr", instr_addr4, 64'h0);
    check("t1_req_valid", 64'(req_valid4), 64'd1);
    check("t1_req_addr0", req_addr4, 64'h0);
    step();
    check("t1_c1_valid", 64'(instr_valid4), 64'd0);
    check("t1_req_addr4", req_addr4, 64'h4);
    step();
`ifdef PREFETCH_STATS_EN
    check("t1_stat_empty", 64'(stat_empty4), 64'd2);
`endif
    for (int k = 0; k < 6; k++) begin
      check("t1_valid", 64'(instr_valid4), 64'd1);
      check("t1_addr", instr_addr4, 64'(4 * k));
      check("t1_instr", 64'(instruction4), 64'h00100093);
      check("t1_req_addr", req_addr4, 64'(4 * (k + 2)));
      step();
    end

    // Stall fills the FIFO, then drains in order
    const_data = 1'b0; lat = 1;
    do_reset();
    stall = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k >= 2) begin
        check("t2_hold_valid", 64'(instr_valid4), 64'd1);
        check("t2_hold_addr", instr_addr4, 64'h0);
      end
      step();
    end
    check("t2_fires", 64'(fires), 64'd4);
    check("t2_req_blocked", 64'(req_valid4), 64'd0);
    stall = 1'b0;
    exp_q = '{64'h0, 64'h4, 64'h8, 64'hC};
    for (int k = 0; k < 4; k++) begin
      exp_a = exp_q.pop_front();
      check("t2_drain_valid", 64'(instr_valid4), 64'd1);
      check("t2_drain_addr", instr_addr4, exp_a);
      check("t2_drain_instr", 64'(instruction4), 64'({exp_a[29:0], 2'b11} ^ 32'hA0000000));
      step();
    end

    // Redirect with three requests in flight to 3-cycle memory
    lat = 3;
    do_reset();
    step(); step(); step();
    check("t3_outstanding", 64'(dut.outstanding_q), 64'd3);
    redirect = 1'b1; redirect_pc = 64'h100;
    #1;
    check("t3_req_in_redirect", 64'(req_valid4), 64'd0);
    step();
    redirect = 1'b0;
    #1;
    check("t3_drop_cnt", 64'(dut.drop_cnt_q), 64'd2);
    check("t3_req_addr", req_addr4, 64'h100);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (instr_valid4) found = 1'b1;
      else step();
    end
    check("t3_seen", 64'(found), 64'd1);
    check("t3_cycle", 64'(cyc), 64'd8);
    check("t3_addr", instr_addr4, 64'h100);
    check("t3_instr", 64'(instruction4), 64'hA0000403);
`ifdef PREFETCH_STATS_EN
    check("t3_stat_dropped", 64'(stat_dropped4), 64'd3);
`endif

    // Memory not ready: address held, nothing in flight
    lat = 1;
    do_reset();
    mem_req_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("t4_req_valid", 64'(req_valid4), 64'd1);
      check("t4_req_addr", req_addr4, 64'h0);
      step();
    end
    check("t4_fires", 64'(fires), 64'd0);
    check("t4_outstanding", 64'(dut.outstanding_q), 64'd0);
    mem_req_ready = 1'b1;
    step(); step();
    check("t4_valid", 64'(instr_valid4), 64'd1);
    check("t4_addr", instr_addr4, 64'h0);

    // Redirect, response and pop in the same cycle
    lat = 2;
    do_reset();
    for (int k = 0; k < 5; k++) step();
    check("t5_pre_valid", 64'(instr_valid4), 64'd1);
    check("t5_pre_addr", instr_addr4, 64'h8);
    check("t5_pre_outstanding", 64'(dut.outstanding_q), 64'd2);
    redirect = 1'b1; redirect_pc = 64'h200;
    step();
    redirect = 1'b0;
    #1;
    check("t5_empty", 64'(instr_valid4), 64'd0);
    check("t5_nop", 64'(instruction4), 64'h13);
    check("t5_drop_cnt", 64'(dut.drop_cnt_q), 64'd1);
    check("t5_req_addr", req_addr4, 64'h200);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (instr_valid4) found = 1'b1;
      else step();
    end
    check("t5_seen", 64'(found), 64'd1);
    check("t5_cycle", 64'(cyc), 64'd9);
    check("t5_addr", instr_addr4, 64'h200);
    check("t5_instr", 64'(instruction4), 64'hA0000803);

    // Reset mid-operation on the deep instance: 3 entries, 2 in flight
    sel8 = 1'b1; lat = 3;
    do_reset();
    stall = 1'b1;
    for (int k = 0; k < 5; k++) step();
    mem_req_ready = 1'b0;
    step();
    check("t6_count", 64'(dut8.count_q), 64'd3);
    check("t6_outstanding", 64'(dut8.outstanding_q), 64'd2);
    check("t6_head", instr_addr8, 64'h1000);
    mq_addr.delete();
    mq_due.delete();
    reset = 1'b1;
    step();
    check("t6_valid", 64'(instr_valid8), 64'd0);
    check("t6_instr", 64'(instruction8), 64'h13);
    check("t6_addr", instr_addr8, 64'h0);
    check("t6_req_addr", req_addr8, 64'h1000);
    check("t6_req_valid", 64'(req_valid8), 64'd0);
`ifdef PREFETCH_STATS_EN
    check("t6_stat_dropped", 64'(stat_dropped8), 64'd0);
    check("t6_stat_empty", 64'(stat_empty8), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
